// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a load/store unit and the data memory controller.
// The requester uses the master modport, the controller the slave modport.
interface data_mem_ctrl_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              done;
    logic [31:0]       rdata;
    logic              err;

    modport master (
        output req, we, funct3, addr, wdata,
        input  ready, done, rdata, err
    );

    modport slave (
        input  req, we, funct3, addr, wdata,
        output ready, done, rdata, err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32-style byte-addressable data memory with B/H/W loads and stores.
// Accesses that cross a word boundary take two beats, or are rejected when misalignment is disabled.
module data_mem_ctrl #(
    parameter int unsigned ADDR_W           = 8,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    data_mem_ctrl_if.slave bus
);
    localparam int unsigned WordW = ADDR_W - 2;
    localparam int unsigned Words = 1 << WordW;
    localparam logic [WordW-1:0] IdxOne = 1;

    typedef enum logic [0:0] {StIdle, StSecond} state_e;

    state_e state_q, state_d;

    logic [31:0] mem [Words];

    logic        ready_q, done_q, err_q;
    logic [31:0] rdata_q;

    // Context of a two-beat access, captured on the first beat.
    logic             we_q;
    logic [2:0]       funct3_q;
    logic [1:0]       off_q;
    logic [WordW-1:0] idx_nxt_q;
    logic [3:0]       mask_hi_q;
    logic [31:0]      wdata_hi_q;
    logic [31:0]      word0_q;

    logic [1:0]       off;
    logic [WordW-1:0] idx, idx_nxt;
    logic [3:0]       size_mask;
    logic [7:0]       mask8;
    logic [63:0]      wide_wdata;
    logic [63:0]      pair;
    logic [31:0]      lo_raw, hi_raw;
    logic             legal, crossing, accept;

    logic [3:0]       wr_en;
    logic [WordW-1:0] wr_idx;
    logic [31:0]      wr_data;
    logic             complete, capture, res_err;
    logic [31:0]      res_rdata;

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
        logic [31:0] val;
        case (f3)
            3'b000:  val = {{24{raw[7]}}, raw[7:0]};
            3'b001:  val = {{16{raw[15]}}, raw[15:0]};
            3'b100:  val = {24'h000000, raw[7:0]};
            3'b101:  val = {16'h0000, raw[15:0]};
            default: val = raw;
        endcase
        return val;
    endfunction

    always_comb begin
        off     = bus.addr[1:0];
        idx     = bus.addr[ADDR_W-1:2];
        idx_nxt = idx + IdxOne;
        case (bus.funct3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        case (bus.funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !bus.we;
            default:                legal = 1'b0;
        endcase
        crossing   = ((bus.funct3[1:0] == 2'b10) && (off != 2'b00)) ||
                     ((bus.funct3[1:0] == 2'b01) && (off == 2'b11));
        // Bits [7:4] of the lane mask / [63:32] of the data belong to the following word.
        mask8      = {4'b0000, size_mask} << off;
        wide_wdata = {32'h0, bus.wdata} << {off, 3'b000};
        lo_raw     = mem[idx] >> {off, 3'b000};
        pair       = {mem[idx_nxt_q], word0_q} >> {off_q, 3'b000};
        hi_raw     = pair[31:0];
    end

    assign bus.ready = ready_q && (state_q == StIdle);
    assign accept    = bus.ready && bus.req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept && legal && crossing && ALLOW_MISALIGNED) state_d = StSecond;
            StSecond: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_en     = 4'b0000;
        wr_idx    = idx;
        wr_data   = wide_wdata[31:0];
        complete  = 1'b0;
        capture   = 1'b0;
        res_err   = 1'b0;
        res_rdata = 32'h0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!legal || (crossing && !ALLOW_MISALIGNED)) begin
                        complete = 1'b1;
                        res_err  = 1'b1;
                    end else begin
                        if (bus.we) wr_en = mask8[3:0];
                        if (crossing) begin
                            capture = 1'b1;
                        end else begin
                            complete = 1'b1;
                            if (!bus.we) res_rdata = extend(bus.funct3, lo_raw);
                        end
                    end
                end
            end
            StSecond: begin
                wr_idx   = idx_nxt_q;
                wr_data  = wdata_hi_q;
                if (we_q) wr_en = mask_hi_q;
                complete = 1'b1;
                if (!we_q) res_rdata = extend(funct3_q, hi_raw);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
            idx_nxt_q  <= '0;
            mask_hi_q  <= 4'b0000;
            wdata_hi_q <= 32'h0;
            word0_q    <= 32'h0;
        end else begin
            ready_q <= 1'b1;
            done_q  <= complete;
            if (complete) begin
                rdata_q <= res_rdata;
                err_q   <= res_err;
            end
            if (capture) begin
                we_q       <= bus.we;
                funct3_q   <= bus.funct3;
                off_q      <= off;
                idx_nxt_q  <= idx_nxt;
                mask_hi_q  <= mask8[7:4];
                wdata_hi_q <= wide_wdata[63:32];
                word0_q    <= mem[idx];
            end
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_en[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
    end

    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one DUT with misaligned splitting, one that rejects it.
module tb_data_mem_ctrl;
    logic clk;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   lat;
    logic r1;

    data_mem_ctrl_if #(.ADDR_W(8)) bus ();
    data_mem_ctrl_if #(.ADDR_W(8)) bus_na ();

    data_mem_ctrl #(.ADDR_W(8), .ALLOW_MISALIGNED(1'b1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    data_mem_ctrl #(.ADDR_W(8), .ALLOW_MISALIGNED(1'b0)) u_dut_na (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_na)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one access and returns edges from accept to done, plus ready just after accept.
    task automatic op(input bit na, input logic w, input logic [2:0] f3, input logic [7:0] a,
                      input logic [31:0] d, output int l, output logic rdy1);
        @(negedge clk);
        if (na) begin
            bus_na.req = 1'b1; bus_na.we = w; bus_na.funct3 = f3; bus_na.addr = a;
            bus_na.wdata = d;
        end else begin
            bus.req = 1'b1; bus.we = w; bus.funct3 = f3; bus.addr = a; bus.wdata = d;
        end
        @(posedge clk);
        #1;
        if (na) begin
            bus_na.req = 1'b0; rdy1 = bus_na.ready;
        end else begin
            bus.req = 1'b0; rdy1 = bus.ready;
        end
        l = 1;
        while (((na ? bus_na.done : bus.done) !== 1'b1) && l < 4) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic res(input bit na, input string tag, input int l, input int exp_l,
                       input logic rdy1, input logic exp_rdy, input logic [31:0] exp_rd,
                       input logic exp_err);
        chk({tag, " latency"}, 32'(l), 32'(exp_l));
        chk({tag, " ready"}, {31'h0, rdy1}, {31'h0, exp_rdy});
        chk({tag, " rdata"}, na ? bus_na.rdata : bus.rdata, exp_rd);
        chk({tag, " err"}, {31'h0, na ? bus_na.err : bus.err}, {31'h0, exp_err});
    endtask

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b000; bus.addr = 8'h00; bus.wdata = 32'h0;
        bus_na.req = 1'b0; bus_na.we = 1'b0; bus_na.funct3 = 3'b000; bus_na.addr = 8'h00;
        bus_na.wdata = 32'h0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst ready", {31'h0, bus.ready}, 32'h0);
        chk("rst done", {31'h0, bus.done}, 32'h0);
        chk("rst err", {31'h0, bus.err}, 32'h0);
        chk("rst rdata", bus.rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready before first edge", {31'h0, bus.ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("ready after release", {31'h0, bus.ready}, 32'h1);
        chk("na ready after release", {31'h0, bus_na.ready}, 32'h1);

        op(0, 1'b1, 3'b010, 8'h10, 32'h11223344, lat, r1); res(0, "sw 10", lat, 1, r1, 1, 32'h0, 0);
        op(0, 1'b0, 3'b010, 8'h10, 32'h0, lat, r1); res(0, "lw 10", lat, 1, r1, 1, 32'h11223344, 0);
        @(posedge clk);
        #1;
        chk("done pulse width", {31'h0, bus.done}, 32'h0);
        chk("rdata hold", bus.rdata, 32'h11223344);
        op(0, 1'b0, 3'b100, 8'h13, 32'h0, lat, r1); res(0, "lbu 13", lat, 1, r1, 1, 32'h11, 0);
        op(0, 1'b0, 3'b001, 8'h12, 32'h0, lat, r1); res(0, "lh 12", lat, 1, r1, 1, 32'h1122, 0);

        op(0, 1'b1, 3'b010, 8'h04, 32'h55667788, lat, r1); res(0, "sw 04", lat, 1, r1, 1, 32'h0, 0);
        op(0, 1'b1, 3'b000, 8'h05, 32'hDEADBE80, lat, r1); res(0, "sb 05", lat, 1, r1, 1, 32'h0, 0);
        op(0, 1'b0, 3'b000, 8'h05, 32'h0, lat, r1); res(0, "lb 05", lat, 1, r1, 1, 32'hFFFFFF80, 0);
        op(0, 1'b0, 3'b100, 8'h05, 32'h0, lat, r1); res(0, "lbu 05", lat, 1, r1, 1, 32'h80, 0);
        op(0, 1'b0, 3'b010, 8'h04, 32'h0, lat, r1); res(0, "lw 04", lat, 1, r1, 1, 32'h55668088, 0);

        op(0, 1'b1, 3'b010, 8'h0E, 32'hAABBCCDD, lat, r1); res(0, "sw 0e", lat, 2, r1, 0, 32'h0, 0);
        op(0, 1'b0, 3'b010, 8'h0E, 32'h0, lat, r1); res(0, "lw 0e", lat, 2, r1, 0, 32'hAABBCCDD, 0);
        op(0, 1'b0, 3'b001, 8'h0F, 32'h0, lat, r1); res(0, "lh 0f", lat, 2, r1, 0, 32'hFFFFBBCC, 0);
        op(0, 1'b0, 3'b010, 8'h10, 32'h0, lat, r1); res(0, "lw 10 after", lat, 1, r1, 1, 32'h1122AABB, 0);
        op(0, 1'b0, 3'b101, 8'h11, 32'h0, lat, r1); res(0, "lhu 11", lat, 1, r1, 1, 32'h22AA, 0);

        op(0, 1'b1, 3'b010, 8'hFE, 32'h01020304, lat, r1); res(0, "sw fe", lat, 2, r1, 0, 32'h0, 0);
        op(0, 1'b0, 3'b101, 8'h00, 32'h0, lat, r1); res(0, "lhu 00", lat, 1, r1, 1, 32'h0102, 0);
        op(0, 1'b0, 3'b100, 8'hFF, 32'h0, lat, r1); res(0, "lbu ff", lat, 1, r1, 1, 32'h03, 0);
        op(0, 1'b0, 3'b101, 8'hFE, 32'h0, lat, r1); res(0, "lhu fe", lat, 1, r1, 1, 32'h0304, 0);
        op(0, 1'b0, 3'b001, 8'hFF, 32'h0, lat, r1); res(0, "lh ff", lat, 2, r1, 0, 32'h0203, 0);

        op(0, 1'b1, 3'b011, 8'h10, 32'hFFFFFFFF, lat, r1); res(0, "st f3=011", lat, 1, r1, 1, 32'h0, 1);
        op(0, 1'b1, 3'b100, 8'h10, 32'hFFFFFFFF, lat, r1); res(0, "st f3=100", lat, 1, r1, 1, 32'h0, 1);
        op(0, 1'b0, 3'b111, 8'h10, 32'h0, lat, r1); res(0, "ld f3=111", lat, 1, r1, 1, 32'h0, 1);
        op(0, 1'b0, 3'b010, 8'h10, 32'h0, lat, r1); res(0, "lw 10 kept", lat, 1, r1, 1, 32'h1122AABB, 0);

        op(1, 1'b1, 3'b010, 8'h00, 32'h12345678, lat, r1); res(1, "na sw 00", lat, 1, r1, 1, 32'h0, 0);
        op(1, 1'b1, 3'b010, 8'h04, 32'h9ABCDEF0, lat, r1); res(1, "na sw 04", lat, 1, r1, 1, 32'h0, 0);
        op(1, 1'b0, 3'b010, 8'h01, 32'h0, lat, r1); res(1, "na lw 01", lat, 1, r1, 1, 32'h0, 1);
        op(1, 1'b1, 3'b010, 8'h02, 32'hFFFFFFFF, lat, r1); res(1, "na sw 02", lat, 1, r1, 1, 32'h0, 1);
        op(1, 1'b0, 3'b010, 8'h00, 32'h0, lat, r1); res(1, "na lw 00", lat, 1, r1, 1, 32'h12345678, 0);
        op(1, 1'b0, 3'b010, 8'h04, 32'h0, lat, r1); res(1, "na lw 04", lat, 1, r1, 1, 32'h9ABCDEF0, 0);
        op(1, 1'b0, 3'b001, 8'h01, 32'h0, lat, r1); res(1, "na lh 01", lat, 1, r1, 1, 32'h3456, 0);
        op(1, 1'b0, 3'b001, 8'h03, 32'h0, lat, r1); res(1, "na lh 03", lat, 1, r1, 1, 32'h0, 1);

        // Abort a two-beat store by resetting between its beats.
        op(0, 1'b0, 3'b101, 8'h10, 32'h0, lat, r1); res(0, "lhu 10 pre", lat, 1, r1, 1, 32'hAABB, 0);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b010; bus.addr = 8'h0E; bus.wdata = 32'h55667788;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        chk("abort ready in second", {31'h0, bus.ready}, 32'h0);
        chk("abort done in second", {31'h0, bus.done}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort rst ready", {31'h0, bus.ready}, 32'h0);
        chk("abort rst rdata", bus.rdata, 32'h0);
        chk("abort rst err", {31'h0, bus.err}, 32'h0);
        @(posedge clk);
        #1;
        chk("abort done in reset", {31'h0, bus.done}, 32'h0);
        chk("abort ready in reset", {31'h0, bus.ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort ready after release", {31'h0, bus.ready}, 32'h0);
        @(posedge clk);
        #1;
        chk("abort ready first edge", {31'h0, bus.ready}, 32'h1);
        chk("abort no done", {31'h0, bus.done}, 32'h0);
        op(0, 1'b0, 3'b101, 8'h0E, 32'h0, lat, r1); res(0, "lhu 0e post", lat, 1, r1, 1, 32'h7788, 0);
        op(0, 1'b0, 3'b101, 8'h10, 32'h0, lat, r1); res(0, "lhu 10 post", lat, 1, r1, 1, 32'hAABB, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width; capacity SHALL be 2^ADDR_W bytes (ADDR_W >= 3).
REQ-002 Parameter ALLOW_MISALIGNED, default 1; 1 = word-crossing accesses split into two beats, 0 = such accesses rejected with err.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req  in  1  access request; accepted at a rising edge where req && ready.
REQ-006 we  in  1  1 = store, 0 = load; sampled with req.
REQ-007 funct3  in  3  RV32 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-008 addr  in  ADDR_W  byte address, sampled with req.
REQ-009 wdata  in  32  store data, sampled with req; byte 0 = wdata[7:0].
REQ-010 ready  out  1  block can accept a request this cycle.
REQ-011 done  out  1  one-cycle pulse, access complete (loads and stores).
REQ-012 rdata  out  32  load result, valid while done=1.
REQ-013 err  out  1  error flag, valid while done=1.

Function
REQ-014 Storage: 2^(ADDR_W-2) 32-bit words with 4 byte lanes, little-endian (byte at addr[1:0]=k in lane k).
REQ-015 Crossing access: W with addr[1:0]!=0, or H/HU with addr[1:0]=3; all other accesses, including H at addr[1:0]=1, are single-beat.
REQ-016 FSM states: IDLE (ready=1), SECOND (ready=0); any non-accepted cycle leaves state unchanged.
REQ-017 IDLE, single-beat access accepted at edge E0: store lanes written at E0; done=1, rdata, err registered at E0; state stays IDLE, so back-to-back requests are accepted at every edge.
REQ-018 IDLE, crossing access accepted at E0 with ALLOW_MISALIGNED=1: first word's lanes accessed at E0, go to SECOND; at E1 the next word (word index +1, wrapping from last word to word 0) is accessed, done pulses after E1, return to IDLE.
REQ-019 Crossing access with ALLOW_MISALIGNED=0: no memory write; done=1, err=1, rdata=0 after E0; stay IDLE.
REQ-020 Load results: B/H sign-extend bit 7/15, BU/HU zero-extend, W unmodified; assembled from bytes at addr..addr+size-1 modulo 2^ADDR_W.
REQ-021 Illegal codes (011, 110, 111; 100/101 with we=1): no memory write, done=1, err=1, rdata=0, single cycle.
REQ-022 Stores: done=1, err=0, rdata=0.
REQ-023 done SHALL be 0 in every cycle not immediately following a completing edge; rdata and err hold their last values while done=0.
REQ-024 req, we, funct3, addr, wdata are ignored while ready=0; the requester holds them until accepted.
REQ-025 Memory contents are not initialised and not cleared by reset.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state=IDLE, ready=0, done=0, err=0, rdata=0.
REQ-027 ready SHALL be 1 from the first rising edge after rst_n deasserts.
REQ-028 Reset in SECOND aborts the access: first-beat bytes remain written, second-beat bytes are unchanged, no done pulse.

Verification
REQ-029 SW 0x11223344 @0x10; LW @0x10 -> done next cycle, rdata=0x11223344; LBU @0x13 -> 0x00000011; LH @0x12 -> 0x00001122.
REQ-030 SB 0x80 @0x05; LB @0x05 -> 0xFFFFFF80; LBU @0x05 -> 0x00000080; bytes 0x04/0x06 unchanged.
REQ-031 SW 0xAABBCCDD @0x0E -> ready=0 one cycle, done at second edge; LW @0x0E -> 0xAABBCCDD two cycles after accept; LH @0x0F -> 0xFFFFBBCC.
REQ-032 ADDR_W=8: SW 0x01020304 @0xFE -> byte 0xFE=04, 0xFF=03, 0x00=02, 0x01=01; LHU @0x00 -> 0x00000102.
REQ-033 funct3=011 with we=1 -> done=1, err=1, memory unchanged; ALLOW_MISALIGNED=0, LW @0x01 -> err=1, rdata=0, ready never drops.
REQ-034 SW 0xAABBCCDD @0x0E, rst_n low in SECOND -> bytes 0x0E/0x0F written, 0x10/0x11 unchanged, done=0, ready=0 during reset, ready=1 after the first edge following release.
